// File: rtl/clause_loader.sv
// Clause loader: holds a host-written clause buffer and streams it into the
// distribution unit, then issues finish plus the decision literal and waits for the solve outcome.
module clause_loader #(
    parameter int DEPTH   = 64,
    parameter int CLA_W   = 24,
    parameter int LIT_W   = 8,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     host_we,
    input  logic [$clog2(DEPTH)-1:0] host_waddr,
    input  logic [CLA_W-1:0]         host_wdata,
    input  logic [$clog2(DEPTH):0]   host_num_cla,
    input  logic [LIT_W-1:0]         host_uc,
    input  logic                     host_go,
    output logic                     busy,
    output logic                     done,
    output logic                     res_conflict,
    output logic                     res_timeout,
    output logic                     mem2carb_start,
    output logic                     mem2carb_finish,
    output logic [CLA_W-1:0]         mem2carb_clause,
    output logic                     mem2carb_uc_valid,
    output logic [LIT_W-1:0]         mem2carb_uc,
    input  logic                     carb_empty,
    input  logic                     conflict
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, STREAM, FIN, WAIT, DONE} state_t;

    state_t           state_reg;
    logic [CLA_W-1:0] clause_mem [DEPTH];
    logic [NW-1:0]    num_reg;
    logic [NW-1:0]    idx_reg;
    logic [LIT_W-1:0] uc_reg;
    logic [CW-1:0]    cnt_reg;
    logic             conflict_reg;

    logic [NW-1:0]    num_next;
    logic [AW-1:0]    rd_addr;
    logic [CLA_W-1:0] rd_data;

    assign num_next = (host_num_cla > NW'(DEPTH)) ? NW'(DEPTH) : host_num_cla;
    // Clause 0 is fetched in the go cycle itself, before any same-cycle write lands.
    assign rd_addr  = (state_reg == IDLE) ? '0 : idx_reg[AW-1:0];
    assign rd_data  = clause_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (state_reg == IDLE && host_we) begin
            clause_mem[host_waddr] <= host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            num_reg           <= '0;
            idx_reg           <= '0;
            uc_reg            <= '0;
            cnt_reg           <= '0;
            conflict_reg      <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            res_conflict      <= 1'b0;
            res_timeout       <= 1'b0;
            mem2carb_start    <= 1'b0;
            mem2carb_finish   <= 1'b0;
            mem2carb_clause   <= '0;
            mem2carb_uc_valid <= 1'b0;
            mem2carb_uc       <= '0;
        end else begin
            mem2carb_start    <= 1'b0;
            mem2carb_finish   <= 1'b0;
            mem2carb_clause   <= '0;
            mem2carb_uc_valid <= 1'b0;
            mem2carb_uc       <= '0;
            done              <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (host_go) begin
                        busy         <= 1'b1;
                        res_conflict <= 1'b0;
                        res_timeout  <= 1'b0;
                        conflict_reg <= 1'b0;
                        num_reg      <= num_next;
                        uc_reg       <= host_uc;
                        if (num_next == '0) begin
                            state_reg         <= FIN;
                            mem2carb_finish   <= 1'b1;
                            mem2carb_uc_valid <= 1'b1;
                            mem2carb_uc       <= host_uc;
                        end else begin
                            state_reg       <= STREAM;
                            mem2carb_start  <= 1'b1;
                            mem2carb_clause <= rd_data;
                            idx_reg         <= NW'(1);
                        end
                    end
                end
                STREAM: begin
                    // Conflicts never abort the stream; the receiver still needs finish.
                    conflict_reg <= conflict_reg | conflict;
                    if (idx_reg == num_reg) begin
                        state_reg         <= FIN;
                        mem2carb_finish   <= 1'b1;
                        mem2carb_uc_valid <= 1'b1;
                        mem2carb_uc       <= uc_reg;
                    end else begin
                        mem2carb_start  <= 1'b1;
                        mem2carb_clause <= rd_data;
                        idx_reg         <= idx_reg + NW'(1);
                    end
                end
                FIN: begin
                    conflict_reg <= conflict_reg | conflict;
                    cnt_reg      <= '0;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    if (cnt_reg != CW'(TIMEOUT)) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                    if (conflict_reg || conflict) begin
                        res_conflict <= 1'b1;
                        done         <= 1'b1;
                        state_reg    <= DONE;
                    end else if (cnt_reg >= CW'(SETTLE - 1) && carb_empty) begin
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        res_timeout <= 1'b1;
                        done        <= 1'b1;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clause_loader.sv
// Randomized bench for clause_loader: a transaction-level model predicts the
// per-cycle stream, the completion cycle and the result flags.
module tb_clause_loader;
    localparam int DEPTH   = 64;
    localparam int CLA_W   = 24;
    localparam int LIT_W   = 8;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 10;
    localparam int AW      = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             host_we;
    logic [AW-1:0]    host_waddr;
    logic [CLA_W-1:0] host_wdata;
    logic [AW:0]      host_num_cla;
    logic [LIT_W-1:0] host_uc;
    logic             host_go;
    logic             busy, done, res_conflict, res_timeout;
    logic             mem2carb_start, mem2carb_finish, mem2carb_uc_valid;
    logic [CLA_W-1:0] mem2carb_clause;
    logic [LIT_W-1:0] mem2carb_uc;
    logic             carb_empty, conflict;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               n_txn   = 0;
    logic [CLA_W-1:0] model_buf [DEPTH];

    clause_loader #(
        .DEPTH(DEPTH), .CLA_W(CLA_W), .LIT_W(LIT_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .host_num_cla(host_num_cla), .host_uc(host_uc), .host_go(host_go),
        .busy(busy), .done(done), .res_conflict(res_conflict), .res_timeout(res_timeout),
        .mem2carb_start(mem2carb_start), .mem2carb_finish(mem2carb_finish),
        .mem2carb_clause(mem2carb_clause), .mem2carb_uc_valid(mem2carb_uc_valid),
        .mem2carb_uc(mem2carb_uc), .carb_empty(carb_empty), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_clause(input int addr, input logic [CLA_W-1:0] data);
        host_we    = 1'b1;
        host_waddr = AW'(addr);
        host_wdata = data;
        @(negedge clk);
        host_we = 1'b0;
        model_buf[addr] = data;
    endtask

    // rc: cycle after go carrying a conflict pulse (0 = none); re: first cycle with carb_empty (0 = never)
    task automatic run_txn(input int num, input logic [LIT_W-1:0] uc, input int rc, input int re,
                           input bit noise);
        int  n, rd, r;
        bit  exp_c, exp_t, exp_fin, exp_start;
        n     = (num > DEPTH) ? DEPTH : num;
        rd    = 0;
        exp_c = 1'b0;
        exp_t = 1'b0;
        if (rc >= 1 && rc <= n + 1) begin
            rd    = n + 3;
            exp_c = 1'b1;
        end else begin
            for (int c = 0; c < TIMEOUT && rd == 0; c++) begin
                r = n + 2 + c;
                if (r == rc) begin
                    rd = r + 1; exp_c = 1'b1;
                end else if (c >= SETTLE - 1 && re >= 1 && r >= re) begin
                    rd = r + 1;
                end else if (c == TIMEOUT - 1) begin
                    rd = r + 1; exp_t = 1'b1;
                end
            end
        end

        host_go      = 1'b1;
        host_num_cla = (AW + 1)'(num);
        host_uc      = uc;
        conflict     = 1'b0;
        carb_empty   = 1'b0;
        for (r = 1; r <= rd + 1; r++) begin
            @(negedge clk);
            exp_start = (r <= n);
            exp_fin   = (r == n + 1);
            check("start", 32'(mem2carb_start), 32'(exp_start));
            check("clause", 32'(mem2carb_clause), exp_start ? 32'(model_buf[r-1]) : 32'd0);
            check("finish", 32'(mem2carb_finish), 32'(exp_fin));
            check("uc_valid", 32'(mem2carb_uc_valid), 32'(exp_fin));
            check("uc", 32'(mem2carb_uc), exp_fin ? 32'(uc) : 32'd0);
            check("busy", 32'(busy), 32'(r <= rd));
            check("done", 32'(done), 32'(r == rd));
            if (r == 1) begin
                check("res_clr_c", 32'(res_conflict), 32'd0);
                check("res_clr_t", 32'(res_timeout), 32'd0);
            end
            if (r >= rd) begin
                check("res_conflict", 32'(res_conflict), 32'(exp_c));
                check("res_timeout", 32'(res_timeout), 32'(exp_t));
            end
            host_go    = noise && (r <= n);
            host_we    = noise && (r <= n);
            host_waddr = AW'($urandom_range(0, DEPTH - 1));
            host_wdata = CLA_W'($urandom);
            conflict   = (r == rc);
            carb_empty = (re >= 1 && r >= re);
        end
        host_go    = 1'b0;
        host_we    = 1'b0;
        conflict   = 1'b0;
        carb_empty = 1'b0;
        n_txn++;
        $display("[TB] txn %0d num=%0d uc=%0h rc=%0d re=%0d noise=%0d done@%0d conflict=%0d timeout=%0d",
                 n_txn, num, uc, rc, re, noise, rd, exp_c, exp_t);
    endtask

    initial begin
        rst = 1'b1; host_we = 1'b0; host_waddr = '0; host_wdata = '0;
        host_num_cla = '0; host_uc = '0; host_go = 1'b0; carb_empty = 1'b0; conflict = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_start", 32'(mem2carb_start), 32'd0);
        check("rst_finish", 32'(mem2carb_finish), 32'd0);
        check("rst_uc_valid", 32'(mem2carb_uc_valid), 32'd0);
        check("rst_res", 32'({res_conflict, res_timeout}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) write_clause(i, CLA_W'($urandom));
        write_clause(0, 24'h010203);
        write_clause(1, 24'h040506);
        write_clause(2, 24'h070809);
        write_clause(3, 24'h0A0B0C);

        run_txn(4, 8'h05, 0, 1, 1'b0);     // basic stream, done at T+8
        run_txn(0, 8'h11, 0, 1, 1'b0);     // empty stream, done at T+4
        run_txn(3, 8'h22, 2, 1, 1'b0);     // conflict during 2nd clause, done at T+6
        run_txn(1, 8'h33, 0, 0, 1'b0);     // watchdog, done at T+13
        run_txn(2, 8'h44, 0, 1, 1'b0);     // flags cleared by the next go
        run_txn(100, 8'h55, 0, 1, 1'b1);   // clamp to DEPTH with mid-stream noise
        run_txn(2, 8'h66, 6, 6, 1'b0);     // conflict and empty together in WAIT

        // Reset in WAIT: everything drops next cycle, no done
        host_go = 1'b1; host_num_cla = 7'd2; host_uc = 8'h77;
        @(negedge clk);
        host_go = 1'b0;
        repeat (4) @(negedge clk);
        check("wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("wrst_busy", 32'(busy), 32'd0);
        check("wrst_done", 32'(done), 32'd0);
        check("wrst_strobes", 32'({mem2carb_start, mem2carb_finish, mem2carb_uc_valid}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        run_txn(3, 8'h88, 0, 2, 1'b0);

        for (int t = 0; t < 30; t++) begin
            int num, rc, re;
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) write_clause($urandom_range(0, DEPTH - 1), CLA_W'($urandom));
            num = $urandom_range(0, 70);
            rc  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (num > DEPTH ? DEPTH : num) + 12) : 0;
            re  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, (num > DEPTH ? DEPTH : num) + 14);
            run_txn(num, LIT_W'($urandom), rc, re, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
